// File: rtl/fetch_unit.sv
//==============================================================================
// fetch_unit : owns the PC, runs the imem request/ready handshake, holds the
//              fetched instruction for the decoder.             Rev 1.0
//==============================================================================
`default_nettype none

module fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   input  logic        stall,
   input  logic        take_branch,
   input  logic [31:0] branch_target,
   output logic [31:0] instr,
   output logic [6:0]  op,
   output logic [2:0]  func3,
   output logic [6:0]  func7,
   output logic [31:0] pc,
   output logic [31:0] pc_plus4,
   output logic        instr_valid,
   output logic        misaligned
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2,
      HALT = 2'd3
   } state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] instr_q;
   logic        req_q;
   logic        valid_q;
   logic        mis_q;
   logic [31:0] pc_inc_d;

   assign pc_inc_d = pc_q + 32'd4;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
         mis_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_q <= REQ;
               req_q   <= 1'b1;
            end
            REQ: begin
               if (imem_ready) begin
                  instr_q <= imem_rdata;
                  valid_q <= 1'b1;
                  req_q   <= 1'b0;
                  state_q <= HOLD;
               end
            end
            HOLD: begin
               // Branch inputs are only meaningful once downstream releases us.
               if (!stall) begin
                  valid_q <= 1'b0;
                  instr_q <= NOP_INSTR;
                  if (!take_branch) begin
                     pc_q    <= pc_inc_d;
                     req_q   <= 1'b1;
                     state_q <= REQ;
                  end else if (branch_target[1:0] == 2'b00) begin
                     pc_q    <= branch_target;
                     req_q   <= 1'b1;
                     state_q <= REQ;
                  end else begin
                     mis_q   <= 1'b1;
                     state_q <= HALT;
                  end
               end
            end
            HALT: begin
               state_q <= HALT;
            end
            default: begin
               state_q <= IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   // instr_q is reloaded with NOP_INSTR whenever nothing is held, so the
   // field slices read as the NOP fields without extra muxing.
   assign imem_req    = req_q;
   assign imem_addr   = pc_q;
   assign instr       = instr_q;
   assign op          = instr_q[6:0];
   assign func3       = instr_q[14:12];
   assign func7       = instr_q[31:25];
   assign pc          = pc_q;
   assign pc_plus4    = pc_inc_d;
   assign instr_valid = valid_q;
   assign misaligned  = mis_q;

endmodule

`default_nettype wire
